// File: rtl/exec_mem_unit_if.sv
// Datapath bus for exec_mem_unit: PC, ALU operands/results and data-memory signals.
// flags_q exists only when ALU_FLAGS_REG_EN is defined.
interface exec_mem_unit_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned DATA_W = 8
);
  logic [PC_W-1:0]   pc_in;
  logic [PC_W-1:0]   pc_out;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [1:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
`ifdef ALU_FLAGS_REG_EN
  logic [3:0]        flags_q;
`endif

  modport master (
    output pc_in, alu_a, alu_b, alu_ctrl, mem_we,
`ifdef ALU_FLAGS_REG_EN
    input  flags_q,
`endif
    input  pc_out, alu_result, alu_flags, mem_rdata
  );

  modport slave (
    input  pc_in, alu_a, alu_b, alu_ctrl, mem_we,
`ifdef ALU_FLAGS_REG_EN
    output flags_q,
`endif
    output pc_out, alu_result, alu_flags, mem_rdata
  );
endinterface

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: PC register, 8-bit ALU with NZCV flags, byte-wide data memory.
// Optional ALU_FLAGS_REG_EN adds a registered copy of the flags (flags_q).
module exec_mem_unit #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input logic               clk,
  input logic               rst_n,
  exec_mem_unit_if.slave    bus
);
  localparam int unsigned AddrW = $clog2(MEM_DEPTH);
  localparam int unsigned Msb   = DATA_W - 1;

  typedef enum logic [1:0] {OpAdd, OpSub, OpAnd, OpOr} alu_op_e;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] result;
  logic              flag_c, flag_v;
  logic [AddrW-1:0]  addr;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // PC register
  assign pc_d = bus.pc_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_out = pc_q;

  // SUB reuses the adder as a + ~b + 1, so C=1 means no borrow.
  always_comb begin
    b_op   = (bus.alu_ctrl == OpSub) ? ~bus.alu_b : bus.alu_b;
    sum    = {1'b0, bus.alu_a} + {1'b0, b_op} +
             {{DATA_W{1'b0}}, (bus.alu_ctrl == OpSub)};
    result = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    unique case (alu_op_e'(bus.alu_ctrl))
      OpAdd: begin
        result = sum[Msb:0];
        flag_c = sum[DATA_W];
        flag_v = (bus.alu_a[Msb] == bus.alu_b[Msb]) && (result[Msb] != bus.alu_a[Msb]);
      end
      OpSub: begin
        result = sum[Msb:0];
        flag_c = sum[DATA_W];
        flag_v = (bus.alu_a[Msb] != bus.alu_b[Msb]) && (result[Msb] != bus.alu_a[Msb]);
      end
      OpAnd: result = bus.alu_a & bus.alu_b;
      OpOr:  result = bus.alu_a | bus.alu_b;
      default: result = '0;
    endcase
  end

  assign bus.alu_result = result;
  assign bus.alu_flags  = {result[Msb], (result == '0), flag_c, flag_v};

  // Data memory: upper address bits are dropped, so addresses alias.
  assign addr = result[AddrW-1:0];

  always_ff @(posedge clk) begin
    if (rst_n && (bus.mem_we === 1'b1)) begin
      mem_q[addr] <= bus.alu_b;
    end
  end

  assign bus.mem_rdata = mem_q[addr];

  mem_we_known_a: assert property (@(posedge clk) rst_n |-> !$isunknown(bus.mem_we))
    else $error("mem_we unknown at clock edge");

`ifdef ALU_FLAGS_REG_EN
  logic [3:0] flag_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg_q <= 4'b0000;
    end else begin
      flag_reg_q <= bus.alu_flags;
    end
  end

  assign bus.flags_q = flag_reg_q;
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// Scoreboard bench for exec_mem_unit: stimulus queues expectations, a monitor pops and compares.
module tb_exec_mem_unit;
  localparam int unsigned PC_W   = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum int {KPc, KRes, KFlags, KRdata, KFlagsQ} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  exec_mem_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

  exec_mem_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .MEM_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(kind_e k);
    logic [15:0] v;
    v = 'x;
    case (k)
      KPc:     v = bus.pc_out;
      KRes:    v = {8'h00, bus.alu_result};
      KFlags:  v = {12'h000, bus.alu_flags};
      KRdata:  v = {8'h00, bus.mem_rdata};
`ifdef ALU_FLAGS_REG_EN
      KFlagsQ: v = {12'h000, bus.flags_q};
`endif
      default: v = 'x;
    endcase
    return v;
  endfunction

  // Monitor: drains every expectation queued before each sample strobe.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = observe(e.kind);
        n_checks++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic exp_val(input string name, input kind_e k, input logic [15:0] v);
    sb_q.push_back('{name: name, kind: k, val: v});
  endtask

  task automatic sample();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic drive_alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bus.alu_a    = a;
    bus.alu_b    = b;
    bus.alu_ctrl = op;
  endtask

  task automatic alu_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] res, input logic [3:0] fl);
    @(negedge clk);
    drive_alu(a, b, op);
    exp_val({name, "_res"}, KRes, {8'h00, res});
    exp_val({name, "_flags"}, KFlags, {12'h000, fl});
    sample();
  endtask

  initial begin
    bus.pc_in  = 16'h0000;
    bus.mem_we = 1'b0;
    drive_alu(8'h00, 8'h00, 2'b00);

    // Reset and PC load
    exp_val("pc_reset", KPc, 16'h0000);
`ifdef ALU_FLAGS_REG_EN
    exp_val("flagsq_reset", KFlagsQ, 16'h0000);
`endif
    sample();
    @(negedge clk);
    rst_n     = 1'b1;
    bus.pc_in = 16'h1234;
    @(posedge clk);
    exp_val("pc_1234", KPc, 16'h1234);
    sample();
    rst_n = 1'b0;
    exp_val("pc_async_rst", KPc, 16'h0000);
    sample();
    @(negedge clk);
    rst_n     = 1'b1;
    bus.pc_in = 16'h0002;
    @(posedge clk);
    exp_val("pc_0002", KPc, 16'h0002);
    sample();
    bus.pc_in = 16'hFFFE;
    @(posedge clk);
    exp_val("pc_fffe", KPc, 16'hFFFE);
    sample();

    // ALU vectors; flags are {N,Z,C,V}
    alu_vec("add_7f_01", 8'h7F, 8'h01, 2'b00, 8'h80, 4'b1001);
    alu_vec("add_ff_01", 8'hFF, 8'h01, 2'b00, 8'h00, 4'b0110);
    alu_vec("sub_05_05", 8'h05, 8'h05, 2'b01, 8'h00, 4'b0110);
    alu_vec("sub_00_01", 8'h00, 8'h01, 2'b01, 8'hFF, 4'b1000);
    alu_vec("sub_80_01", 8'h80, 8'h01, 2'b01, 8'h7F, 4'b0011);
    alu_vec("and_f0_0f", 8'hF0, 8'h0F, 2'b10, 8'h00, 4'b0100);
    alu_vec("or_f0_0f",  8'hF0, 8'h0F, 2'b11, 8'hFF, 4'b1000);

    // Store 0x04 at 0x10, then load it back
    @(negedge clk);
    drive_alu(8'h0C, 8'h04, 2'b00);
    bus.mem_we = 1'b1;
    exp_val("st_addr", KRes, 16'h0010);
    sample();
    @(posedge clk);
    #1;
    bus.mem_we = 1'b0;
    drive_alu(8'h10, 8'h00, 2'b00);
    exp_val("ld_addr", KRes, 16'h0010);
    exp_val("ld_flags", KFlags, 16'h0000);
    exp_val("ld_data", KRdata, 16'h0004);
    sample();

    // Write attempt during reset must be blocked
    @(negedge clk);
    drive_alu(8'h08, 8'h08, 2'b00);
    rst_n      = 1'b0;
    bus.mem_we = 1'b1;
    exp_val("rst_pc", KPc, 16'h0000);
    sample();
    @(posedge clk);
    #1;
    bus.mem_we = 1'b0;
    drive_alu(8'h10, 8'h00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    exp_val("rst_blocked_wr", KRdata, 16'h0004);
    sample();

    // Wrapped address 0x99+0x77=0x110 -> 0x10: old data until the edge, new after
    @(negedge clk);
    drive_alu(8'h99, 8'h77, 2'b00);
    bus.mem_we = 1'b1;
    exp_val("wrap_res", KRes, 16'h0010);
    exp_val("wrap_flags", KFlags, 16'h0002);
    exp_val("rdw_old", KRdata, 16'h0004);
    sample();
    @(posedge clk);
    #1;
    bus.mem_we = 1'b0;
    exp_val("rdw_new", KRdata, 16'h0077);
    sample();

`ifdef ALU_FLAGS_REG_EN
    @(negedge clk);
    drive_alu(8'h05, 8'h05, 2'b01);
    @(posedge clk);
    exp_val("flagsq_sub", KFlagsQ, 16'h0006);
    sample();
    rst_n = 1'b0;
    exp_val("flagsq_async_rst", KFlagsQ, 16'h0000);
    sample();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
